// File: rtl/fir_pkg.sv
// Shared types, widths and the output rounding/saturation helper for the
// symmetric FIR MAC scheduler.
package fir_pkg;

    localparam int TAPS      = 64;
    localparam int DW        = 24;
    localparam int CW        = 16;
    localparam int COEF_FRAC = 15;
    localparam int ACC_W     = 48;
    localparam int HALF_TAPS = TAPS / 2;
    localparam int AW        = $clog2(HALF_TAPS);
    localparam int PW        = $clog2(TAPS);
    localparam int PRE_W     = DW + 1;
    localparam int PROD_W    = PRE_W + CW;
    localparam int DRAIN_CYC = 3;

    // Half an LSB of the output scale, and the clip limits, all at accumulator width.
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_e;

    // Round half up, drop the coefficient fraction, clip to DW bits. Returns {sat, data}.
    function automatic logic [DW:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND_HALF) >>> COEF_FRAC;
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[DW-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[DW-1:0]};
        end
        return {1'b0, r[DW-1:0]};
    endfunction

endpackage

// File: rtl/booth_mul.sv
// Combinational radix-4 Booth signed multiplier. The output is one bit wider
// than the exact product; the top bit carries no information.
module booth_mul import fir_pkg::*; #(
    parameter int A_W = PRE_W,
    parameter int B_W = CW
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [A_W+B_W:0] c
);

    localparam int C_W = A_W + B_W + 1;

    logic [B_W:0]          b_ext;
    logic signed [C_W-1:0] a_ext;
    logic signed [C_W-1:0] pp;
    logic signed [C_W-1:0] sum;

    assign b_ext = {b, 1'b0};
    assign a_ext = {{(C_W-A_W){a[A_W-1]}}, a};

    // Recode b in overlapping bit triplets and sum the shifted partial products.
    always_comb begin
        pp  = '0;
        sum = '0;
        for (int i = 0; i < B_W / 2; i++) begin
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            sum = sum + (pp <<< (2 * i));
        end
    end

    assign c = sum;

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed MAC scheduler for the symmetric FIR: delay line, pre-adder,
// shared multiplier, accumulator and a single-entry output register.
//
// state | meaning
// IDLE  | waiting for an input sample, in_ready high
// MAC   | one symmetric tap pair per cycle, coef_addr = k
// DRAIN | three cycles while the last pairs flow through mul and accumulate
// OUT   | rounded sample presented until out_ready
module fir_mac_sched import fir_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat
);

    state_e state, state_nxt;

    logic [PW-1:0]             wp;
    logic [AW-1:0]             k;
    logic [1:0]                drain_cnt;
    logic signed [DW-1:0]      dline [TAPS];
    logic [PW-1:0]             idx_new;
    logic [PW-1:0]             idx_old;
    logic signed [PRE_W-1:0]   preadd_r;
    logic signed [PROD_W-1:0]  prod_r;
    logic signed [PROD_W:0]    mul_c;
    logic signed [ACC_W-1:0]   acc;
    logic                      pre_vld;
    logic                      prod_vld;
    logic                      accept;
    logic                      mac_last;
    logic                      drain_last;
    logic                      mul_unused;

    assign accept     = (state == IDLE) && in_valid;
    assign mac_last   = (k == AW'(HALF_TAPS - 1));
    assign drain_last = (drain_cnt == 2'd0);
    assign coef_addr  = k;

    // Pair k: newest-k and oldest+k, both modulo the delay-line length.
    assign idx_new = wp - PW'(k);
    assign idx_old = wp + PW'(k) + PW'(1);

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC: begin
                if (mac_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, tap index and drain down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k <= '0;
            end else if (state == MAC) begin
                k <= k + AW'(1);
            end
            if (state == MAC && mac_last) begin
                drain_cnt <= 2'(DRAIN_CYC - 1);
            end else if (state == DRAIN && !drain_last) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
        end
    end

    // Sample delay line; wp always points at the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
        end else if (accept) begin
            dline[wp + PW'(1)] <= in_data;
            wp                 <= wp + PW'(1);
        end
    end

    booth_mul #(.A_W(PRE_W), .B_W(CW)) u_mul (
        .a (preadd_r),
        .b (coef_data),
        .c (mul_c)
    );

    assign mul_unused = mul_c[PROD_W];

    // Pre-add and product stages; coef_data arrives in step with preadd_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_vld  <= 1'b0;
            prod_vld <= 1'b0;
            preadd_r <= '0;
            prod_r   <= '0;
        end else begin
            pre_vld  <= (state == MAC);
            prod_vld <= pre_vld;
            if (state == MAC) begin
                preadd_r <= PRE_W'(dline[idx_new]) + PRE_W'(dline[idx_old]);
            end
            prod_r <= mul_c[PROD_W-1:0];
        end
    end

    // Accumulator, cleared when a new sample is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= acc + ACC_W'(prod_r);
        end
    end

    // Output register, loaded once on entry to OUT and held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat  <= 1'b0;
            out_data <= '0;
        end else if (state == DRAIN && drain_last) begin
            {out_sat, out_data} <= sat_round(acc);
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: table vectors, directed corner
// sequences and randomized samples against a direct-convolution model.
module tb_fir_mac_sched;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [23:0] in_data = '0;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [23:0] out_data;
    logic               out_sat;

    logic signed [15:0] rom [32];
    longint             hist [64];
    int                 n_tests = 0;
    int                 n_fail = 0;

    typedef struct {
        logic signed [15:0] coef0;
        logic signed [23:0] x;
        logic signed [23:0] exp_d;
        logic               exp_s;
    } vec_t;

    vec_t vecs [10];

    fir_mac_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous coefficient ROM.
    always @(posedge clk) coef_data <= rom[coef_addr];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 64; j++) hist[j] = 0;
    endtask

    task automatic model_push(input logic signed [23:0] x);
        for (int j = 63; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
    endtask

    // Full 64-tap convolution with the symmetric coefficient set.
    task automatic model_out(output longint d, output longint s);
        longint a;
        longint r;
        a = 0;
        for (int j = 0; j < 64; j++) a += longint'(rom[j < 32 ? j : 63 - j]) * hist[j];
        r = (a + 16384) >>> 15;
        if (r > 8388607) begin
            d = 8388607; s = 1;
        end else if (r < -8388608) begin
            d = -8388608; s = 1;
        end else begin
            d = r; s = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rom_fill(input logic signed [15:0] c0, input logic signed [15:0] rest);
        for (int j = 0; j < 32; j++) rom[j] = rest;
        rom[0] = c0;
    endtask

    // Push one sample through, optionally stalling OUT, checking against the model.
    task automatic do_sample(input logic signed [23:0] x, input int stall,
                             output longint d, output longint s, output int lat);
        int     n;
        longint ed, es;
        in_data = x; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        model_push(x);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("out_valid wait", out_valid, 1);
        d = out_data; s = out_sat;
        model_out(ed, es);
        check("data vs model", d, ed);
        check("sat vs model", s, es);
        if (stall > 0) begin
            out_ready = 1'b0; in_valid = 1'b1; in_data = 24'sh123456;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check("held out_valid", out_valid, 1);
                check("held out_data", out_data, d);
                check("held out_sat", out_sat, s);
                check("in_ready in OUT", in_ready, 0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle after handshake", in_ready, 1);
        check("out_valid after handshake", out_valid, 0);
    endtask

    task automatic run_impulse();
        longint d, s;
        int     lat;
        rom_fill(16'sd16384, 16'sd0);
        for (int n = 0; n < 64; n++) begin
            do_sample((n == 0) ? 24'sd1048576 : 24'sd0, 0, d, s, lat);
            check($sformatf("impulse out%0d data", n), d, (n == 0 || n == 63) ? 524288 : 0);
            check($sformatf("impulse out%0d sat", n), s, 0);
        end
    endtask

    initial begin
        longint d, s, ed, es;
        int     lat, bad;

        vecs[0] = '{16'sd1,     24'sd16384,    24'sd1,        1'b0};
        vecs[1] = '{16'sd1,     -24'sd16384,   24'sd0,        1'b0};
        vecs[2] = '{16'sd16384, 24'sd1048576,  24'sd524288,   1'b0};
        vecs[3] = '{16'sd16384, 24'sd3,        24'sd2,        1'b0};
        vecs[4] = '{16'sd16384, -24'sd3,       -24'sd1,       1'b0};
        vecs[5] = '{16'sd32767, 24'sd1,        24'sd1,        1'b0};
        vecs[6] = '{16'sh8000,  24'sd1,        -24'sd1,       1'b0};
        vecs[7] = '{16'sh8000,  24'sh800000,   24'sd8388607,  1'b1};
        vecs[8] = '{16'sh8000,  24'sd8388607,  -24'sd8388607, 1'b0};
        vecs[9] = '{16'sd16384, -24'sd1,       24'sd0,        1'b0};

        rom_fill(16'sd0, 16'sd0);
        do_reset();

        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sat", out_sat, 0);
        check("reset coef_addr", coef_addr, 0);

        // Single samples from a fresh reset: output is coef0 * x, rounded.
        for (int i = 0; i < 10; i++) begin
            rom_fill(vecs[i].coef0, 16'sd0);
            do_reset();
            do_sample(vecs[i].x, 0, d, s, lat);
            check($sformatf("vec%0d data", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d sat", i), s, vecs[i].exp_s);
        end

        // Latency and coefficient address sequence.
        rom_fill(16'sd16384, 16'sd0);
        do_reset();
        in_data = 24'sd1000; in_valid = 1'b1;
        check("latency accept ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(24'sd1000);
        for (int j = 0; j < 32; j++) begin
            check($sformatf("mac coef_addr k%0d", j), coef_addr, j);
            check("mac in_ready", in_ready, 0);
            check("mac out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        lat = 32; bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad++;
            @(posedge clk); #1; lat++;
        end
        check("latency accept to out_valid", lat, 35);
        check("in_ready low before output", bad, 0);
        model_out(ed, es);
        check("latency data", out_data, ed);
        check("latency data const", out_data, 500);
        @(posedge clk); #1;
        check("latency back to idle", in_ready, 1);

        // Impulse response from reset.
        do_reset();
        run_impulse();

        // Saturation, positive then negative.
        rom_fill(16'sd32767, 16'sd32767);
        do_reset();
        for (int n = 0; n < 64; n++) do_sample(24'sd8388607, 0, d, s, lat);
        check("sat pos data", d, 8388607);
        check("sat pos flag", s, 1);
        do_reset();
        for (int n = 0; n < 64; n++) do_sample(24'sh800000, 0, d, s, lat);
        check("sat neg data", d, -8388608);
        check("sat neg flag", s, 1);

        // Backpressure with in_valid poked during OUT, then a normal sample.
        for (int j = 0; j < 32; j++) rom[j] = 16'(j * 300 - 4000);
        do_reset();
        do_sample(24'sd12345, 10, d, s, lat);
        do_sample(-24'sd54321, 0, d, s, lat);
        do_sample(24'sd777, 0, d, s, lat);

        // Reset in the middle of MAC with a non-empty delay line.
        in_data = 24'sd4242; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("mid-mac coef_addr", coef_addr, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("post-reset in_ready", in_ready, 1);
        check("post-reset out_valid", out_valid, 0);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("no output after abandon", bad, 0);
        run_impulse();

        // Randomized coefficients, samples and backpressure.
        for (int j = 0; j < 32; j++) rom[j] = 16'($urandom);
        do_reset();
        for (int n = 0; n < 48; n++) begin
            logic signed [23:0] x;
            int                 v;
            int                 st;
            v = int'($urandom_range(0, 2000));
            x = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'(v - 1000);
            st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_sample(x, st, d, s, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
